// File: rtl/keypad_scan_module.sv
// keypad_scan_module
//   Scans a 4x4 active-low key matrix one column at a time, debounces press
//   and release of the first key found, and reports one key code per press.
//
// Ports
//   CLK        system clock, rising edge
//   RSTn       asynchronous active-low reset
//   Row_In     matrix rows, active-low, asynchronous to CLK
//   Col_Scan   matrix columns, active-low one-cold drive
//   Key_Code   last accepted key, {row[1:0], col[1:0]}
//   Key_Valid  one-clock pulse per accepted press
//   Key_Down   high from press acceptance until release acceptance
//
// Parameters
//   SCAN_DIV   clocks per scan tick (column dwell), >= 4
//   DEB_COUNT  consecutive qualifying ticks to accept a press/release, >= 1

module keypad_scan_module #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned DEB_COUNT = 20
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [3:0] Row_In,
    output logic [3:0] Col_Scan,
    output logic [3:0] Key_Code,
    output logic       Key_Valid,
    output logic       Key_Down
);

    localparam int unsigned   TW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned   DW        = $clog2(DEB_COUNT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
    // Counter value just before the qualifying tick that completes a debounce.
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_COUNT - 1);
    localparam bit            DEB_ONE   = (DEB_COUNT == 1);

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DEB,
        HELD,
        REL_DEB
    } state_t;

    // Row synchroniser
    logic [3:0]    r_rows_m;
    logic [3:0]    r_rows_s;

    // Tick generator
    logic [TW-1:0] r_tick_cnt;
    logic          w_tick;

    // FSM and datapath
    state_t        r_state,  w_state_nxt;
    logic [1:0]    r_col,    w_col_nxt;
    logic [1:0]    r_row,    w_row_nxt;
    logic [DW-1:0] r_deb,    w_deb_nxt;
    logic [3:0]    r_code,   w_code_nxt;
    logic          r_valid,  w_valid_nxt;
    logic          r_down,   w_down_nxt;

    logic          w_any_low;
    logic [1:0]    w_low_row;
    logic          w_trk_low;

    // Sync flops idle at "no key" so reset release never looks like a press.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_rows_m <= '1;
            r_rows_s <= '1;
        end else begin
            r_rows_m <= Row_In;
            r_rows_s <= r_rows_m;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Lowest-numbered low row wins within the active column.
    always_comb begin
        w_any_low = (r_rows_s != 4'b1111);
        if (!r_rows_s[0]) begin
            w_low_row = 2'd0;
        end else if (!r_rows_s[1]) begin
            w_low_row = 2'd1;
        end else if (!r_rows_s[2]) begin
            w_low_row = 2'd2;
        end else begin
            w_low_row = 2'd3;
        end
    end

    assign w_trk_low = ~r_rows_s[r_row];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= SCAN;
            r_col   <= '0;
            r_row   <= '0;
            r_deb   <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_down  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_deb   <= w_deb_nxt;
            r_code  <= w_code_nxt;
            r_valid <= w_valid_nxt;
            r_down  <= w_down_nxt;
        end
    end

    // All transitions happen on a tick; between ticks only Key_Valid
    // returns to zero, giving a single-clock pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_deb_nxt   = r_deb;
        w_code_nxt  = r_code;
        w_valid_nxt = 1'b0;
        w_down_nxt  = r_down;

        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (!w_any_low) begin
                        w_col_nxt = r_col + 2'd1;
                    end else begin
                        w_row_nxt = w_low_row;
                        if (DEB_ONE) begin
                            w_code_nxt  = {w_low_row, r_col};
                            w_valid_nxt = 1'b1;
                            w_down_nxt  = 1'b1;
                            w_deb_nxt   = '0;
                            w_state_nxt = HELD;
                        end else begin
                            w_deb_nxt   = DW'(1);
                            w_state_nxt = PRESS_DEB;
                        end
                    end
                end

                PRESS_DEB: begin
                    if (w_trk_low) begin
                        if (r_deb == DEB_LAST) begin
                            w_code_nxt  = {r_row, r_col};
                            w_valid_nxt = 1'b1;
                            w_down_nxt  = 1'b1;
                            w_deb_nxt   = '0;
                            w_state_nxt = HELD;
                        end else begin
                            w_deb_nxt = r_deb + DW'(1);
                        end
                    end else begin
                        w_deb_nxt   = '0;
                        w_col_nxt   = r_col + 2'd1;
                        w_state_nxt = SCAN;
                    end
                end

                HELD: begin
                    if (!w_trk_low) begin
                        if (DEB_ONE) begin
                            w_down_nxt  = 1'b0;
                            w_deb_nxt   = '0;
                            w_col_nxt   = r_col + 2'd1;
                            w_state_nxt = SCAN;
                        end else begin
                            w_deb_nxt   = DW'(1);
                            w_state_nxt = REL_DEB;
                        end
                    end
                end

                REL_DEB: begin
                    if (!w_trk_low) begin
                        if (r_deb == DEB_LAST) begin
                            w_down_nxt  = 1'b0;
                            w_deb_nxt   = '0;
                            w_col_nxt   = r_col + 2'd1;
                            w_state_nxt = SCAN;
                        end else begin
                            w_deb_nxt = r_deb + DW'(1);
                        end
                    end else begin
                        w_deb_nxt   = '0;
                        w_state_nxt = HELD;
                    end
                end

                default: begin
                    w_deb_nxt   = '0;
                    w_state_nxt = SCAN;
                end
            endcase
        end
    end

    always_comb begin
        Col_Scan        = 4'b1111;
        Col_Scan[r_col] = 1'b0;
    end

    assign Key_Code  = r_code;
    assign Key_Valid = r_valid;
    assign Key_Down  = r_down;

endmodule

// File: tb/tb_keypad_scan_module.sv
module tb_keypad_scan_module;

    localparam int SD  = 4;
    localparam int DEB = 3;

    logic       CLK  = 1'b0;
    logic       RSTn = 1'b0;
    logic [3:0] Row_In;
    logic [3:0] Col_Scan;
    logic [3:0] Key_Code;
    logic       Key_Valid;
    logic       Key_Down;

    logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c pressed

    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulses   = 0;
    logic pulse_down;

    keypad_scan_module #(
        .SCAN_DIV (SD),
        .DEB_COUNT(DEB)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .Row_In   (Row_In),
        .Col_Scan (Col_Scan),
        .Key_Code (Key_Code),
        .Key_Valid(Key_Valid),
        .Key_Down (Key_Down)
    );

    always #5 CLK = ~CLK;

    // Passive key matrix: a row reads low when a pressed key connects it to
    // a driven (low) column.
    always_comb begin
        Row_In = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && (Col_Scan[c] === 1'b0)) Row_In[r] = 1'b0;
    end

    // ---------------- reference model ----------------
    // Tracks one key: "run" counts consecutive tick samples whose level
    // would flip the key's status (low while pending, high while held).
    logic [3:0] m_p1, m_p2;
    int         m_tcnt, m_col, m_trow, m_run;
    bit         m_tracking, m_holding, m_valid, m_down;
    logic [3:0] m_code;

    task automatic model_reset();
        m_p1 = 4'hF; m_p2 = 4'hF;
        m_tcnt = 0; m_col = 0; m_trow = 0; m_run = 0;
        m_tracking = 0; m_holding = 0; m_valid = 0; m_down = 0;
        m_code = 4'h0;
    endtask

    task automatic model_flip();
        if (!m_holding) begin
            m_code    = 4'(m_trow * 4 + m_col);
            m_valid   = 1;
            m_down    = 1;
            m_holding = 1;
            m_run     = 0;
        end else begin
            m_down     = 0;
            m_holding  = 0;
            m_tracking = 0;
            m_col      = (m_col + 1) % 4;
        end
    endtask

    task automatic model_step(input logic [3:0] rec);
        logic [3:0] rs;
        bit         tick;
        bit         lvl;
        rs   = m_p2;
        m_p2 = m_p1;
        m_p1 = rec;
        tick   = (m_tcnt == SD - 1);
        m_tcnt = (m_tcnt + 1) % SD;
        m_valid = 0;
        if (tick) begin
            if (!m_tracking) begin
                if (rs == 4'hF) begin
                    m_col = (m_col + 1) % 4;
                end else begin
                    for (int r = 3; r >= 0; r--) if (!rs[r]) m_trow = r;
                    m_tracking = 1;
                    m_holding  = 0;
                    m_run      = 1;
                    if (m_run == DEB) model_flip();
                end
            end else begin
                lvl = rs[m_trow];
                if (lvl == m_holding) begin
                    m_run++;
                    if (m_run == DEB) model_flip();
                end else if (m_holding) begin
                    m_run = 0;
                end else begin
                    m_tracking = 0;
                    m_col = (m_col + 1) % 4;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_model();
        logic [3:0] ec;
        ec = 4'b1111;
        ec[m_col] = 1'b0;
        n_checks++;
        if (Col_Scan !== ec || Key_Code !== m_code || Key_Valid !== m_valid || Key_Down !== m_down) begin
            n_fail++;
            $display("FAIL model t=%0t got Col_Scan=%b Key_Code=%b Key_Valid=%b Key_Down=%b expected %b %b %b %b",
                     $time, Col_Scan, Key_Code, Key_Valid, Key_Down, ec, m_code, m_valid, m_down);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0d expected %0d..%0d", name, $time, act, lo, hi);
        end
    endtask

    // One clock: inputs settled before the edge, outputs sampled 1ns after.
    task automatic cyc(input int n);
        logic [3:0] rec;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            #1;
            rec = Row_In;
            @(posedge CLK);
            #1;
            if (!RSTn) model_reset();
            else       model_step(rec);
            if (Key_Valid === 1'b1) begin
                pulses++;
                pulse_down = Key_Down;
            end
            check_model();
        end
    endtask

    typedef struct {
        logic [15:0] mask;
        int          press_cyc;
        int          rel_cyc;
        int          exp_pulses;
        logic [3:0]  exp_code;
        logic [3:0]  exp_col;
    } vec_t;

    vec_t       vecs[7];
    logic [3:0] pat[4];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit         stayed, accepted, found, reached;
        int         k;
        logic [3:0] col_at, seen;
        logic [15:0] tmp;
        int         r;

        vecs[0] = '{16'h0200, 40, 30, 1, 4'b1001, 4'b1101};
        vecs[1] = '{16'h0008, 40, 30, 1, 4'b0011, 4'b0111};
        vecs[2] = '{16'h1010, 40, 30, 1, 4'b0100, 4'b1110};
        vecs[3] = '{16'h8000, 40, 30, 1, 4'b1111, 4'b0111};
        vecs[4] = '{16'h0001, 40, 30, 1, 4'b0000, 4'b1110};
        vecs[5] = '{16'h0400, 40, 30, 1, 4'b1010, 4'b1011};
        vecs[6] = '{16'h0022, 40, 30, 1, 4'b0001, 4'b1101};
        pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111;

        model_reset();
        keys = '0;
        RSTn = 1'b0;
        cyc(3);
        check_val("reset_col", Col_Scan, 4'b1110);
        check_val("reset_code", Key_Code, 4'h0);

        // Test 1: idle scan
        RSTn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            check_val("t1_scan_col", Col_Scan, pat[((i + 1) / 4) % 4]);
        end
        check_val("t1_no_valid", pulses, 0);

        // Test 2: clean press row 2 / column 1
        keys = 16'h0200;
        pulses = 0; stayed = 1; accepted = 0; pulse_down = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (accepted && Col_Scan !== 4'b1101) stayed = 0;
            if (Key_Valid === 1'b1) accepted = 1;
        end
        check_val("t2_pulses", pulses, 1);
        check_val("t2_down_with_pulse", pulse_down, 1);
        check_val("t2_code", Key_Code, 4'b1001);
        check_val("t2_col_frozen", stayed, 1);

        // Test 3: release
        keys = '0;
        found = 0; k = 0; col_at = 4'h0;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            if (!found && Key_Down === 1'b0) begin
                found = 1; k = i; col_at = Col_Scan;
            end
        end
        check_val("t3_released", found, 1);
        check_range("t3_release_latency", k, 11, 14);
        check_val("t3_resume_col", col_at, 4'b1011);
        check_val("t3_code_held", Key_Code, 4'b1001);

        // Test 4: press bounce on row 0 / column 3
        pulses = 0; seen = '0;
        for (int p = 0; p < 10; p++) begin
            keys = 16'h0008;
            for (int i = 0; i < 4; i++) begin cyc(1); seen |= ~Col_Scan; end
            keys = '0;
            for (int i = 0; i < 4; i++) begin cyc(1); seen |= ~Col_Scan; end
        end
        check_val("t4_bounce_no_valid", pulses, 0);
        check_val("t4_scan_resumes", seen, 4'hF);
        keys = 16'h0008;
        cyc(40);
        check_val("t4_steady_pulses", pulses, 1);
        check_val("t4_code", Key_Code, 4'b0011);
        check_val("t4_down", Key_Down, 1);

        // Test 5: release bounce
        stayed = 1;
        keys = '0;
        for (int i = 0; i < 8; i++) begin cyc(1); if (Key_Down !== 1'b1) stayed = 0; end
        keys = 16'h0008;
        for (int i = 0; i < 4; i++) begin cyc(1); if (Key_Down !== 1'b1) stayed = 0; end
        keys = '0;
        for (int i = 0; i < 9; i++) begin cyc(1); if (Key_Down !== 1'b1) stayed = 0; end
        check_val("t5_down_through_bounce", stayed, 1);
        cyc(20);
        check_val("t5_down_dropped", Key_Down, 0);
        check_val("t5_single_pulse", pulses, 1);

        // Test 6: rows 1 and 3 on column 0, then reset during press debounce
        keys = 16'h1010;
        pulses = 0;
        cyc(40);
        check_val("t6_pulses", pulses, 1);
        check_val("t6_code", Key_Code, 4'b0100);
        keys = '0;
        cyc(30);
        keys = 16'h1010;
        reached = 0;
        for (int i = 0; i < 60 && !reached; i++) begin
            cyc(1);
            if (m_tracking && !m_holding) reached = 1;
        end
        check_val("t6_reach_press_deb", reached, 1);
        RSTn = 1'b0;
        #1;
        check_val("t6_rst_col", Col_Scan, 4'b1110);
        check_val("t6_rst_code", Key_Code, 4'h0);
        check_val("t6_rst_valid", Key_Valid, 0);
        check_val("t6_rst_down", Key_Down, 0);
        keys = '0;
        cyc(3);
        RSTn = 1'b1;
        pulses = 0;
        cyc(40);
        check_val("t6_no_valid_after_reset", pulses, 0);

        // Reset while held: Key_Down drops without a clock edge
        keys = 16'h1010;
        reached = 0;
        for (int i = 0; i < 60 && !reached; i++) begin
            cyc(1);
            if (m_holding) reached = 1;
        end
        check_val("held_reached", reached, 1);
        check_val("held_down_before", Key_Down, 1);
        RSTn = 1'b0;
        #1;
        check_val("held_rst_down", Key_Down, 0);
        check_val("held_rst_code", Key_Code, 4'h0);
        keys = '0;
        cyc(2);
        RSTn = 1'b1;

        // Table-driven press/release vectors
        foreach (vecs[v]) begin
            keys = vecs[v].mask;
            pulses = 0;
            cyc(vecs[v].press_cyc);
            check_val($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
            check_val($sformatf("vec%0d_code", v), Key_Code, vecs[v].exp_code);
            check_val($sformatf("vec%0d_col", v), Col_Scan, vecs[v].exp_col);
            check_val($sformatf("vec%0d_down", v), Key_Down, 1);
            keys = '0;
            cyc(vecs[v].rel_cyc);
            check_val($sformatf("vec%0d_released", v), Key_Down, 0);
            check_val($sformatf("vec%0d_code_kept", v), Key_Code, vecs[v].exp_code);
        end

        // Randomised key activity against the model
        for (int s = 0; s < 150; s++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                tmp = '0;
            end else if (r < 85) begin
                tmp = 16'h0001 << $urandom_range(0, 15);
            end else begin
                tmp = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            end
            keys = tmp;
            cyc($urandom_range(1, 48));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
